// File: rtl/clock_controller_pkg.sv
// Package: clock_ctrl_pkg
// Shared types and defaults for the single-steppable CPU clock controller.
//   state_t             - 2-bit FSM state encoding, also exported on the
//                         controller's state port
//   DIV_W_DEF           - default width of the divider register and counter
//   DEBOUNCE_CYCLES_DEF - default number of stable samples for step_btn
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STEP      = 2'd1,
    ST_STEP_HIGH = 2'd2,
    ST_HALTED    = 2'd3
  } state_t;

  localparam int DIV_W_DEF           = 24;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

endpackage

// File: rtl/clock_controller_debouncer.sv
// Module: debouncer
// Conditions the raw manual step button: 2-flop synchronizer, a stability
// counter that accepts a new level only after DEBOUNCE_CYCLES consecutive
// samples that differ from the current debounced level, and a single-cycle
// pulse on each accepted 0->1 transition.
// Ports:
//   sys_clk  in  system clock
//   rst      in  asynchronous active-high reset
//   btn      in  raw, asynchronous button level
//   step_req out one-cycle pulse per debounced press
module debouncer
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic btn,
  output logic step_req
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level;
  logic [CNT_W-1:0] stab_cnt;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      level    <= 1'b0;
      stab_cnt <= '0;
      step_req <= 1'b0;
    end else begin
      sync_q1  <= btn;
      sync_q2  <= sync_q1;
      step_req <= 1'b0;
      // Any sample matching the current level breaks the run of candidates.
      if (sync_q2 == level) begin
        stab_cnt <= '0;
      end else if (stab_cnt == CNT_LAST) begin
        stab_cnt <= '0;
        level    <= sync_q2;
        // Pulse only on the rising acceptance; a release is silent.
        step_req <= sync_q2;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_controller.sv
// Module: clock_controller
// Generates a glitch-free, flop-driven CPU clock from sys_clk with a
// programmable divider, a manual single-step mode and a halt/resume state.
// Ports:
//   sys_clk      in  sole clock
//   rst          in  asynchronous active-high reset
//   mode         in  0 = continuous run, 1 = manual single-step
//   step_btn     in  raw manual step button
//   halt         in  CPU HLT decode level
//   resume       in  one-cycle pulse leaving HALTED
//   div_load     in  one-cycle strobe loading div_value
//   div_value    in  half-period minus one, in sys_clk cycles
//   cpu_clk      out registered CPU clock
//   cpu_clk_rise out high on the first sys_clk cycle cpu_clk is 1
//   state        out FSM state (RUN=0, STEP=1, STEP_HIGH=2, HALTED=3)
module clock_controller
  import clock_ctrl_pkg::*;
#(
  parameter int               DIV_W           = DIV_W_DEF,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter logic [DIV_W-1:0] DIV_RESET       = '0
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             step_btn,
  input  logic             halt,
  input  logic             resume,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  output logic             cpu_clk,
  output logic             cpu_clk_rise,
  output logic [1:0]       state
);

  state_t           st;
  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] counter;
  logic             tc;
  logic             step_req;

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .sys_clk (sys_clk),
    .rst     (rst),
    .btn     (step_btn),
    .step_req(step_req)
  );

  // A divider reload restarts the count, so it masks the terminal count
  // for that cycle.
  assign tc    = (counter == div_reg) && !div_load;
  assign state = st;

  // Divider: counts 0..div_reg, parked at 0 while the clock is stopped so
  // that a restart always begins a full phase.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      div_reg <= DIV_RESET;
      counter <= '0;
    end else if (div_load) begin
      div_reg <= div_value;
      counter <= '0;
    end else if (st == ST_STEP || st == ST_HALTED || tc) begin
      counter <= '0;
    end else begin
      counter <= counter + 1'b1;
    end
  end

  // FSM and clock output flops. cpu_clk_rise is set in exactly the branches
  // that drive cpu_clk from 0 to 1, so it coincides with the first high
  // cycle without a second edge-detect stage.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      st           <= ST_RUN;
      cpu_clk      <= 1'b0;
      cpu_clk_rise <= 1'b0;
    end else begin
      cpu_clk_rise <= 1'b0;
      case (st)
        ST_RUN: begin
          if (tc) begin
            // Stop decisions are taken only at the end of a low phase so a
            // high phase is never cut short.
            if (cpu_clk) begin
              cpu_clk <= 1'b0;
            end else if (halt) begin
              st <= ST_HALTED;
            end else if (mode) begin
              st <= ST_STEP;
            end else begin
              cpu_clk      <= 1'b1;
              cpu_clk_rise <= 1'b1;
            end
          end
        end
        ST_STEP: begin
          cpu_clk <= 1'b0;
          if (halt) begin
            st <= ST_HALTED;
          end else if (step_req) begin
            st           <= ST_STEP_HIGH;
            cpu_clk      <= 1'b1;
            cpu_clk_rise <= 1'b1;
          end else if (!mode) begin
            st <= ST_RUN;
          end
        end
        ST_STEP_HIGH: begin
          // step_req is not looked at here, so presses during the pulse
          // are discarded.
          if (tc) begin
            cpu_clk <= 1'b0;
            st      <= ST_STEP;
          end
        end
        ST_HALTED: begin
          cpu_clk <= 1'b0;
          if (resume && !halt) begin
            st <= mode ? ST_STEP : ST_RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_controller.sv
module tb_clock_controller;

  localparam int DIV_W = 24;

  logic             sys_clk = 1'b0;
  logic             rst;
  logic             mode;
  logic             step_btn;
  logic             halt;
  logic             resume;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             cpu_clk;
  logic             cpu_clk_rise;
  logic [1:0]       state;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;

  clock_controller #(
    .DIV_W          (DIV_W),
    .DEBOUNCE_CYCLES(4),
    .DIV_RESET      (24'd0)
  ) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .mode        (mode),
    .step_btn    (step_btn),
    .halt        (halt),
    .resume      (resume),
    .div_load    (div_load),
    .div_value   (div_value),
    .cpu_clk     (cpu_clk),
    .cpu_clk_rise(cpu_clk_rise),
    .state       (state)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; step_btn = 1'b0; halt = 1'b0;
    resume = 1'b0; div_load = 1'b0; div_value = '0;
    repeat (3) tick();
    checks++;
    if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++;
    if (cpu_clk !== 1'b0) begin failures++; $display("FAIL reset_clk got=%b exp=0", cpu_clk); end
    checks++;
    if (cpu_clk_rise !== 1'b0) begin failures++; $display("FAIL reset_rise got=%b exp=0", cpu_clk_rise); end
    rst = 1'b0;
  endtask

  // div_reg = 0: toggles every cycle, first high right after the first edge.
  task automatic test_run_div0();
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (cpu_clk !== 1'(i % 2)) begin
        failures++; $display("FAIL div0_clk cyc=%0d got=%b exp=%0d", i, cpu_clk, i % 2);
      end
      checks++;
      if (cpu_clk_rise !== 1'(i % 2)) begin
        failures++; $display("FAIL div0_rise cyc=%0d got=%b exp=%0d", i, cpu_clk_rise, i % 2);
      end
    end
  endtask

  // Load 3 while cpu_clk is low: the load cycle suppresses the pending toggle,
  // then 4 low / 4 high.
  task automatic test_div_load();
    div_value = 24'd3; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      checks++;
      if (cpu_clk !== 1'((k / 4) % 2)) begin
        failures++; $display("FAIL div3_clk k=%0d got=%b exp=%0d", k, cpu_clk, (k / 4) % 2);
      end
      checks++;
      if (cpu_clk_rise !== 1'(k % 8 == 4)) begin
        failures++; $display("FAIL div3_rise k=%0d got=%b exp=%0d", k, cpu_clk_rise, (k % 8 == 4));
      end
    end
  endtask

  task automatic test_halt();
    bit found = 0;
    div_value = 24'd1; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_clk_rise) begin found = 1; break; end
      tick();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL halt_wait_rise got=timeout exp=rise"); end
    halt = 1'b1;
    tick();
    checks++;
    if (cpu_clk !== 1'b1 || state !== 2'd0) begin
      failures++; $display("FAIL halt_high_kept got clk=%b st=%0d exp clk=1 st=0", cpu_clk, state);
    end
    tick();
    checks++;
    if (cpu_clk !== 1'b0) begin failures++; $display("FAIL halt_high_end got=%b exp=0", cpu_clk); end
    tick(); tick();
    checks++;
    if (state !== 2'd3 || cpu_clk !== 1'b0) begin
      failures++; $display("FAIL halt_enter got st=%0d clk=%b exp st=3 clk=0", state, cpu_clk);
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    tick(); tick();
    checks++;
    if (state !== 2'd3 || cpu_clk !== 1'b0) begin
      failures++; $display("FAIL halt_resume_ignored got st=%0d clk=%b exp st=3 clk=0", state, cpu_clk);
    end
    halt = 1'b0;
    tick();
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++;
    if (state !== 2'd0) begin failures++; $display("FAIL halt_resume got=%0d exp=0", state); end
  endtask

  task automatic test_step();
    bit found = 0;
    int bad = 0;
    int high = 0;
    int rises = 0;
    int rise_k = -1;
    bit saw_high_state = 0;
    div_value = 24'd2; div_load = 1'b1; mode = 1'b1;
    tick();
    div_load = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (state == 2'd1) begin found = 1; break; end
      tick();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL step_enter got=%0d exp=1", state); end
    // 2-cycle glitch on the button must not step.
    step_btn = 1'b1;
    tick(); tick();
    step_btn = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state !== 2'd1 || cpu_clk !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL step_glitch bad_cycles=%0d exp=0", bad); end
    // 10-cycle press: 2 sync + 4 debounce + 1 FSM cycle before the rise.
    step_btn = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 10) step_btn = 1'b0;
      if (cpu_clk === 1'b1) high++;
      if (cpu_clk_rise === 1'b1) begin rises++; if (rise_k < 0) rise_k = k; end
      if (state === 2'd2) saw_high_state = 1;
    end
    checks++;
    if (high != 3) begin failures++; $display("FAIL step_high_len got=%0d exp=3", high); end
    checks++;
    if (rises != 1) begin failures++; $display("FAIL step_rise_count got=%0d exp=1", rises); end
    checks++;
    if (rise_k != 7) begin failures++; $display("FAIL step_latency got=%0d exp=7", rise_k); end
    checks++;
    if (!saw_high_state || state !== 2'd1) begin
      failures++; $display("FAIL step_states saw2=%0d final=%0d exp saw2=1 final=1", saw_high_state, state);
    end
  endtask

  task automatic test_reset_step_high();
    bit found = 0;
    step_btn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (state == 2'd2) begin found = 1; break; end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL rst_wait_step_high got=%0d exp=2", state); end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (cpu_clk !== 1'b0 || state !== 2'd0 || cpu_clk_rise !== 1'b0) begin
      failures++;
      $display("FAIL rst_async got clk=%b st=%0d rise=%b exp clk=0 st=0 rise=0", cpu_clk, state, cpu_clk_rise);
    end
    mode = 1'b0; step_btn = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (cpu_clk_rise !== 1'b0 || cpu_clk !== 1'b0) begin
      failures++; $display("FAIL rst_first_cycle got clk=%b rise=%b exp 0 0", cpu_clk, cpu_clk_rise);
    end
    // div_reg back at 0 shows as an immediate every-cycle toggle.
    tick();
    checks++;
    if (cpu_clk !== 1'b1) begin failures++; $display("FAIL rst_divreg_c1 got=%b exp=1", cpu_clk); end
    tick();
    checks++;
    if (cpu_clk !== 1'b0) begin failures++; $display("FAIL rst_divreg_c2 got=%b exp=0", cpu_clk); end
  endtask

  initial begin
    test_reset();
    test_run_div0();
    test_div_load();
    test_halt();
    test_step();
    test_reset_step_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_controller.md
CLOCK_CONTROLLER -- requirements
Module: clock_controller

Interface
REQ-001 Parameter DIV_W, default 24, width of divider register and counter.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable sys_clk cycles needed to accept a step_btn level.
REQ-003 Parameter DIV_RESET, default 0, divider value loaded at reset; 0 = cpu_clk toggles every sys_clk.
REQ-004 sys_clk  in  1  sole clock; all state SHALL update on posedge sys_clk.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 mode  in  1  0 = continuous run, 1 = manual single-step.
REQ-007 step_btn  in  1  raw, asynchronous manual step button.
REQ-008 halt  in  1  level from CPU HLT decode, synchronous to sys_clk.
REQ-009 resume  in  1  one-cycle pulse requesting exit from HALTED.
REQ-010 div_load  in  1  one-cycle strobe loading div_value.
REQ-011 div_value  in  DIV_W  half-period minus one, in sys_clk cycles.
REQ-012 cpu_clk  out  1  registered CPU clock, glitch-free.
REQ-013 cpu_clk_rise  out  1  high exactly on the first sys_clk cycle cpu_clk is 1.
REQ-014 state  out  2  current FSM state: RUN=0, STEP=1, STEP_HIGH=2, HALTED=3.

Function
REQ-015 step_btn SHALL pass a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive equal samples; a debounced 0->1 edge SHALL produce one single-cycle step_req.
REQ-016 Divider counter SHALL count 0..div_reg; terminal count (tc) when counter == div_reg, then counter SHALL wrap to 0.
REQ-017 div_load SHALL write div_reg and clear the counter in the same cycle; the new value applies from the next cycle; div_load has priority over tc.
REQ-018 RUN: on each tc, cpu_clk SHALL toggle, giving a period of 2*(div_reg+1) sys_clk cycles.
REQ-019 RUN, tc with cpu_clk==1: cpu_clk SHALL go 0; a high phase SHALL never be truncated.
REQ-020 RUN, tc with cpu_clk==0: if halt==1 -> HALTED; else if mode==1 -> STEP; else cpu_clk goes 1; halt has priority over mode.
REQ-021 STEP: cpu_clk held 0; counter held at 0; on step_req -> STEP_HIGH with cpu_clk=1 on the next cycle; mode==0 -> RUN; halt==1 -> HALTED; halt outranks step_req and mode.
REQ-022 STEP_HIGH: cpu_clk SHALL stay 1 for exactly div_reg+1 cycles, then go 0 and return to STEP; step_req during STEP_HIGH SHALL be dropped, not queued.
REQ-023 HALTED: cpu_clk held 0, counter held at 0; resume with halt==0 -> RUN if mode==0, STEP if mode==1; resume with halt==1 SHALL be ignored.
REQ-024 cpu_clk_rise SHALL equal cpu_clk & ~cpu_clk_prev, registered; at most one pulse per cpu_clk period.
REQ-025 cpu_clk SHALL be driven only from a flop, never from combinational mux of clocks.

Reset
REQ-026 rst asserted SHALL immediately force: state=RUN, cpu_clk=0, cpu_clk_rise=0, counter=0, div_reg=DIV_RESET, synchronizer/debouncer flops=0, debounced level=0.
REQ-027 rst asserted mid-high phase SHALL drop cpu_clk to 0 asynchronously; no cpu_clk_rise SHALL occur in the first cycle after release.
REQ-028 After release, a button held high during reset SHALL NOT generate step_req until released and pressed again... except it SHALL generate one once debounced high is reached, since debounced level resets to 0 -- decided: one step_req is produced after DEBOUNCE_CYCLES.

Structure
REQ-029 Package clock_ctrl_pkg SHALL hold the state enum (2-bit), DIV_W default, DEBOUNCE_CYCLES default.
REQ-030 One sub-module, debouncer (synchronizer + stability counter + edge pulse), instantiated once; FSM, divider and output flops in clock_controller.

Verification
REQ-031 Reset release, mode=0, div_reg=0 -> cpu_clk toggles every cycle, period 2, cpu_clk_rise every 2nd cycle.
REQ-032 div_load with div_value=3 in RUN -> counter cleared, subsequent cpu_clk period 8 cycles, 4 high/4 low.
REQ-033 mode=1, div_reg=2, step_btn pulsed 2 cycles -> no step; held 10 cycles -> exactly one 3-cycle high pulse, state 1->2->1.
REQ-034 RUN, div_reg=1, halt raised during high phase -> high phase completes (2 cycles), state=3, cpu_clk stays 0; resume with halt=1 ignored; halt=0 then resume -> state=0.
REQ-035 rst asserted during STEP_HIGH -> cpu_clk=0 same cycle, state=0, div_reg=DIV_RESET, no cpu_clk_rise on first post-reset cycle.
